// File: rtl/tree_backprop.sv
// Decision-tree backward evaluation engine.
// Holds a topologically ordered node table, folds child values into their
// parents with weighted, saturating accumulation, and reports the root value
// and the best first action.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, wr_addr,
//   wr_parent, wr_reward,
//   wr_weight, wr_action     node-table write port (ignored while busy)
//   num_nodes, start         node count and run request
//   busy, done               run in progress / one-cycle result strobe
//   exp_out, act_out,
//   act_valid, ovf, err      results, held until the next done or reset
module tree_backprop #(
    parameter int W_ADDR   = 10,
    parameter int W_REWARD = 8,
    parameter int W_WEIGHT = 7,
    parameter int W_ACTION = 4,
    parameter int W_ACC    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [W_ADDR-1:0]   wr_addr,
    input  logic [W_ADDR-1:0]   wr_parent,
    input  logic [W_REWARD-1:0] wr_reward,
    input  logic [W_WEIGHT:0]   wr_weight,
    input  logic [W_ACTION-1:0] wr_action,
    input  logic [W_ADDR:0]     num_nodes,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [W_ACC-1:0]    exp_out,
    output logic [W_ACTION-1:0] act_out,
    output logic                act_valid,
    output logic                ovf,
    output logic                err
);

    localparam int N_MAX = 1 << W_ADDR;
    // Working width wide enough for the full product and for every sum.
    localparam int PW = W_ACC + W_WEIGHT + 1;
    localparam logic signed [PW-1:0] HI =
        {{(W_WEIGHT+2){1'b0}}, {(W_ACC-1){1'b1}}};
    localparam logic signed [PW-1:0] LO =
        {{(W_WEIGHT+2){1'b1}}, {(W_ACC-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    logic [W_ADDR-1:0]       par_q [N_MAX];
    logic [W_REWARD-1:0]     rew_q [N_MAX];
    logic [W_WEIGHT:0]       wgt_q [N_MAX];
    logic [W_ACTION-1:0]     act_q [N_MAX];
    logic signed [W_ACC-1:0] acc_q [N_MAX];

    state_t                  state_q;
    logic [W_ADDR:0]         n_q;
    logic [W_ADDR-1:0]       idx_q;
    logic                    best_v_q;
    logic signed [W_ACC-1:0] best_q;
    logic [W_ACTION-1:0]     best_a_q;
    logic                    run_ovf_q;
    logic                    run_err_q;
    logic                    busy_q;
    logic                    done_q;
    logic signed [W_ACC-1:0] exp_q;
    logic [W_ACTION-1:0]     act_out_q;
    logic                    act_valid_q;
    logic                    ovf_q;
    logic                    err_q;

    // Returns {clamped, value}.
    function automatic logic [W_ACC:0] sat(input logic signed [PW-1:0] v);
        if (v > HI) return {1'b1, HI[W_ACC-1:0]};
        if (v < LO) return {1'b1, LO[W_ACC-1:0]};
        return {1'b0, v[W_ACC-1:0]};
    endfunction

    function automatic logic signed [PW-1:0] sx(
        input logic signed [W_ACC-1:0] a);
        return {{(PW-W_ACC){a[W_ACC-1]}}, a};
    endfunction

    logic [W_ADDR-1:0]       cur_par;
    logic signed [W_ACC-1:0] cur_acc;
    logic signed [PW-1:0]    prod_d;
    logic signed [PW-1:0]    step_d;
    logic [W_ACC:0]          upd_d;
    logic [W_ACC:0]          fin_d;
    logic signed [W_ACC-1:0] base_d;
    logic                    skip_d;

    always_comb begin
        cur_par = par_q[idx_q];
        cur_acc = acc_q[idx_q];
        skip_d  = cur_par >= idx_q;
        prod_d  = sx(cur_acc)
                * $signed({{(PW-W_WEIGHT-1){1'b0}}, wgt_q[idx_q]});
        step_d  = prod_d >>> W_WEIGHT;
        upd_d   = sat(sx(acc_q[cur_par]) + step_d);
        // acc[0] is never a fold target, so it always equals reward[0].
        base_d  = (n_q == '0) ? '0 :
                  {{(W_ACC-W_REWARD){rew_q[0][W_REWARD-1]}}, rew_q[0]};
        fin_d   = best_v_q ? sat(sx(base_d) + sx(best_q)) : {1'b0, base_d};
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && !busy_q) begin
            par_q[wr_addr] <= wr_parent;
            rew_q[wr_addr] <= wr_reward;
            wgt_q[wr_addr] <= wr_weight;
            act_q[wr_addr] <= wr_action;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            for (int i = 0; i < N_MAX; i++) begin
                acc_q[i] <= {{(W_ACC-W_REWARD){rew_q[i][W_REWARD-1]}},
                             rew_q[i]};
            end
        end else if (state_q == RUN && !skip_d && cur_par != '0) begin
            acc_q[cur_par] <= upd_d[W_ACC-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            best_v_q    <= 1'b0;
            best_q      <= '0;
            best_a_q    <= '0;
            run_ovf_q   <= 1'b0;
            run_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exp_q       <= '0;
            act_out_q   <= '0;
            act_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // busy stays up through the done cycle, which is
                    // spent here; a start in that cycle is not accepted.
                    busy_q <= 1'b0;
                    if (start && !busy_q) begin
                        busy_q    <= 1'b1;
                        n_q       <= num_nodes;
                        best_v_q  <= 1'b0;
                        run_ovf_q <= 1'b0;
                        run_err_q <= 1'b0;
                        state_q   <= (num_nodes < 2) ? DONE : INIT;
                    end
                end
                INIT: begin
                    idx_q   <= W_ADDR'(n_q - 1'b1);
                    state_q <= RUN;
                end
                RUN: begin
                    if (skip_d) begin
                        run_err_q <= 1'b1;
                    end else if (cur_par != '0) begin
                        if (upd_d[W_ACC]) run_ovf_q <= 1'b1;
                    end else if (!best_v_q || cur_acc >= best_q) begin
                        best_v_q <= 1'b1;
                        best_q   <= cur_acc;
                        best_a_q <= act_q[idx_q];
                    end
                    idx_q <= idx_q - 1'b1;
                    if (idx_q == W_ADDR'(1)) state_q <= DONE;
                end
                DONE: begin
                    done_q      <= 1'b1;
                    exp_q       <= fin_d[W_ACC-1:0];
                    act_out_q   <= best_v_q ? best_a_q : '0;
                    act_valid_q <= best_v_q;
                    ovf_q       <= run_ovf_q | fin_d[W_ACC];
                    err_q       <= run_err_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign exp_out   = exp_q;
    assign act_out   = act_out_q;
    assign act_valid = act_valid_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tree_backprop.sv
// Self-checking bench for tree_backprop: directed scenarios plus random
// trees, compared against a behavioural tree-evaluation model.
module tb_tree_backprop;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [9:0]  wr_parent;
    logic [7:0]  wr_reward;
    logic [7:0]  wr_weight;
    logic [3:0]  wr_action;
    logic [10:0] num_nodes;
    logic        start0, start1;

    logic        busy0, done0, av0, ovf0, err0;
    logic [15:0] exp0;
    logic [3:0]  act0;
    logic        busy1, done1, av1, ovf1, err1;
    logic [9:0]  exp1;
    logic [3:0]  act1;

    int total = 0;
    int bad   = 0;

    int m_par [1024];
    int m_rew [1024];
    int m_wgt [1024];
    int m_act [1024];

    always #5 clk = ~clk;

    tree_backprop u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_parent(wr_parent), .wr_reward(wr_reward),
        .wr_weight(wr_weight), .wr_action(wr_action),
        .num_nodes(num_nodes), .start(start0), .busy(busy0),
        .done(done0), .exp_out(exp0), .act_out(act0),
        .act_valid(av0), .ovf(ovf0), .err(err0)
    );

    tree_backprop #(.W_ADDR(4), .W_ACC(10)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[3:0]),
        .wr_parent(wr_parent[3:0]), .wr_reward(wr_reward),
        .wr_weight(wr_weight), .wr_action(wr_action),
        .num_nodes(num_nodes[4:0]), .start(start1), .busy(busy1),
        .done(done1), .exp_out(exp1), .act_out(act1),
        .act_valid(av1), .ovf(ovf1), .err(err1)
    );

    task automatic chk(input string tag, input longint obs,
                       input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: walk nodes from the highest index down to 1, folding each
    // child into its parent; root children compete for the best action.
    function automatic void model(input int n, input int wacc,
                                  output longint e, output int a,
                                  output bit v, output bit o,
                                  output bit er);
        longint acc [1024];
        longint hi, lo, best, t, x, q;
        hi = (longint'(1) << (wacc - 1)) - 1;
        lo = -hi - 1;
        v = 0; o = 0; er = 0; a = 0; best = 0;
        for (int i = 0; i < n; i++) acc[i] = m_rew[i];
        for (int i = n - 1; i >= 1; i--) begin
            int p;
            p = m_par[i];
            if (p >= i) begin
                er = 1;
            end else if (p != 0) begin
                x = acc[i] * m_wgt[i];
                q = x / 128;
                if (x < 0 && q * 128 != x) q = q - 1;
                t = acc[p] + q;
                if (t > hi) begin t = hi; o = 1; end
                if (t < lo) begin t = lo; o = 1; end
                acc[p] = t;
            end else if (!v || acc[i] >= best) begin
                v = 1; best = acc[i]; a = m_act[i];
            end
        end
        e = (n == 0) ? 0 : m_rew[0];
        if (v) begin
            e = e + best;
            if (e > hi) begin e = hi; o = 1; end
            if (e < lo) begin e = lo; o = 1; end
        end
    endfunction

    task automatic wr(input int a, input int p, input int r,
                      input int w, input int ac);
        wr_en = 1'b1;
        wr_addr = 10'(a);
        wr_parent = 10'(p);
        wr_reward = 8'(r);
        wr_weight = 8'(w);
        wr_action = 4'(ac);
        m_par[a] = p; m_rew[a] = r; m_wgt[a] = w; m_act[a] = ac;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic run(input int sel, input int n, input bit disturb,
                       input string tag);
        longint e; int a; bit v, o, er; int lat, el;
        model(n, sel ? 10 : 16, e, a, v, o, er);
        num_nodes = 11'(n);
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 1100; c++) begin
            if (disturb && c == 2) begin
                wr_en = 1'b1; wr_addr = 10'd2; wr_reward = 8'd100;
                start0 = 1'b1;
            end
            @(posedge clk); #1;
            wr_en = 1'b0; start0 = 1'b0;
            if ((sel != 0) ? done1 : done0) begin lat = c; break; end
        end
        el = (n <= 1) ? 1 : n + 1;
        chk({tag, ".lat"}, lat, el);
        if (sel != 0) begin
            chk({tag, ".busy"}, busy1, 1);
            chk({tag, ".exp"}, longint'($signed(exp1)), e);
            chk({tag, ".act"}, act1, a);
            chk({tag, ".av"}, av1, v);
            chk({tag, ".ovf"}, ovf1, o);
            chk({tag, ".err"}, err1, er);
        end else begin
            chk({tag, ".busy"}, busy0, 1);
            chk({tag, ".exp"}, longint'($signed(exp0)), e);
            chk({tag, ".act"}, act0, a);
            chk({tag, ".av"}, av0, v);
            chk({tag, ".ovf"}, ovf0, o);
            chk({tag, ".err"}, err0, er);
        end
        @(posedge clk); #1;
        chk({tag, ".idle"}, (sel != 0) ? busy1 : busy0, 0);
    endtask

    task automatic base_table();
        wr(0, 0, 0, 0, 0);
        wr(1, 0, 2, 128, 3);
        wr(2, 0, 1, 128, 5);
        wr(3, 2, 10, 64, 0);
        wr(4, 2, 4, 64, 0);
    endtask

    initial begin
        int seen, n, p;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_parent = '0;
        wr_reward = '0; wr_weight = '0; wr_action = '0;
        num_nodes = '0; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy0, 0);
        chk("rst.done", done0, 0);
        chk("rst.exp", exp0, 0);
        chk("rst.act", act0, 0);
        chk("rst.av", av0, 0);
        chk("rst.ovf", ovf0, 0);
        chk("rst.err", err0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        base_table();
        run(0, 5, 0, "basic");
        chk("basic.exp8", longint'($signed(exp0)), 8);
        chk("basic.act5", act0, 5);

        wr(1, 0, 8, 128, 3);
        run(0, 5, 0, "tie");
        chk("tie.act3", act0, 3);
        chk("tie.exp8", longint'($signed(exp0)), 8);

        wr(1, 0, 2, 128, 3);
        wr(3, 4, 10, 64, 0);
        run(0, 5, 0, "malformed");
        chk("malformed.err1", err0, 1);
        chk("malformed.exp3", longint'($signed(exp0)), 3);

        wr(3, 2, 10, 64, 0);
        num_nodes = 11'd5;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.busy", busy0, 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (done0) seen++;
            @(posedge clk); #1;
        end
        chk("abort.nodone", seen, 0);
        run(0, 5, 0, "restart");
        chk("restart.exp8", longint'($signed(exp0)), 8);

        run(0, 5, 1, "disturb");
        chk("disturb.exp8", longint'($signed(exp0)), 8);

        wr(0, 0, -3, 0, 0);
        run(0, 1, 0, "n1");
        chk("n1.expm3", longint'($signed(exp0)), -3);
        run(0, 0, 0, "n0");

        for (int i = 0; i < 10; i++) wr(i, (i == 0) ? 0 : i - 1, 127, 255, i);
        run(1, 10, 0, "chain");
        chk("chain.exp511", longint'($signed(exp1)), 511);
        chk("chain.ovf1", ovf1, 1);

        for (int it = 0; it < 16; it++) begin
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) begin
                if (i == 0) p = 0;
                else if ($urandom_range(0, 9) == 0) p = $urandom_range(i, 1023);
                else p = $urandom_range(0, i - 1);
                wr(i, p, int'($urandom_range(0, 255)) - 128,
                   $urandom_range(0, 255), $urandom_range(0, 15));
            end
            run(0, n, 0, $sformatf("rnd0_%0d", it));
        end

        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(2, 16);
            for (int i = 0; i < n; i++) begin
                if (i == 0) p = 0;
                else if ($urandom_range(0, 7) == 0) p = $urandom_range(i, 15);
                else p = $urandom_range(0, i - 1);
                wr(i, p, int'($urandom_range(0, 255)) - 128,
                   $urandom_range(128, 255), $urandom_range(0, 15));
            end
            run(1, n, 0, $sformatf("rnd1_%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tree_backprop.md
TREE_BACKPROP -- requirements
Module: tree_backprop

Interface
REQ-001 Parameter W_ADDR, default 10, node-index width; table depth N_MAX = 2^W_ADDR.
REQ-002 Parameter W_REWARD, default 8, signed per-node reward width.
REQ-003 Parameter W_WEIGHT, default 7, weight fraction bits; weight is unsigned Q1.W_WEIGHT, so 2^W_WEIGHT = 1.0.
REQ-004 Parameter W_ACTION, default 4, action-id width.
REQ-005 Parameter W_ACC, default 16, signed accumulator width; W_ACC > W_REWARD.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  write one node-table entry this cycle.
REQ-009 wr_addr  in  W_ADDR  node index written.
REQ-010 wr_parent  in  W_ADDR  parent index of node.
REQ-011 wr_reward  in  W_REWARD  signed immediate reward of node.
REQ-012 wr_weight  in  W_WEIGHT+1  transition probability/weight toward parent.
REQ-013 wr_action  in  W_ACTION  action id, meaningful only for children of node 0.
REQ-014 num_nodes  in  W_ADDR+1  node count N, sampled with start.
REQ-015 start  in  1  begin evaluation.
REQ-016 busy  out  1  high from accepted start until done cycle inclusive.
REQ-017 done  out  1  one-cycle pulse, results valid.
REQ-018 exp_out  out  W_ACC  root expected value.
REQ-019 act_out  out  W_ACTION  best initial action.
REQ-020 act_valid  out  1  at least one root child existed.
REQ-021 ovf  out  1  sticky, a saturation occurred in last run.
REQ-022 err  out  1  sticky, a malformed node was skipped in last run.

Function
REQ-023 Node table SHALL be written when wr_en=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-024 States: IDLE, INIT, RUN, DONE; start accepted only in IDLE; start while busy ignored.
REQ-025 IDLE, start=1: latch N; N<=1 -> DONE directly; else -> INIT.
REQ-026 INIT (1 cycle): acc[i] <= sign-extended reward[i] for all i; best cleared; ovf, err cleared; idx <= N-1; -> RUN.
REQ-027 RUN processes one node per cycle at idx, descending; after idx=1 -> DONE.
REQ-028 Node idx with parent p >= idx SHALL be skipped and set err.
REQ-029 If p != 0: acc[p] <= sat(acc[p] + ((acc[idx] * weight[idx]) >>> W_WEIGHT)); arithmetic shift (floor); product formed at W_ACC+W_WEIGHT+1 bits before shift.
REQ-030 If p == 0: candidate value = acc[idx]; replace best (value, action) when no best yet or value >= best value (ties: lowest node index wins).
REQ-031 sat() clamps to [-2^(W_ACC-1), 2^(W_ACC-1)-1]; any clamp sets ovf.
REQ-032 DONE (1 cycle): exp_out <= sat(acc[0] + best value) if best exists, else acc[0]; act_out <= best action else 0; act_valid accordingly; done=1; -> IDLE.
REQ-033 For N<=1: exp_out = sign-extended reward[0] (N=1) or 0 (N=0), act_valid=0.
REQ-034 Latency: done asserted exactly N+1 cycles after start-accepting edge for N>=2; 1 cycle for N<=1.
REQ-035 Outputs exp_out, act_out, act_valid, ovf, err SHALL hold until next DONE or reset.
REQ-036 Nodes are stored topologically (parent index < child index); node 0 is root.

Reset
REQ-037 rst SHALL force IDLE, busy=0, done=0, exp_out=0, act_out=0, act_valid=0, ovf=0, err=0, taking priority over start and wr_en.
REQ-038 Node table contents SHALL NOT be cleared by rst; rst mid-run aborts with no done pulse.

Verification
REQ-039 Table {0:p0 r0; 1:p0 a3 r2; 2:p0 a5 r1; 3:p2 w64 r10; 4:p2 w64 r4}, N=5, start -> done 6 cycles later, exp_out=8, act_out=5, act_valid=1, ovf=0, err=0.
REQ-040 Same table with node1 r=8 -> tie at 8; act_out=3 (lower index), exp_out=8.
REQ-041 W_ACC=10, 10-node chain i->i-1, all reward 127, weight 255 -> exp_out=511, ovf=1.
REQ-042 Node 3 with parent 4 in a 5-node table -> node 3 skipped, err=1, remaining result consistent.
REQ-043 rst asserted 2 cycles into RUN -> busy=0 next cycle, no done; restart without rewrite yields REQ-039 result.
REQ-044 wr_en and start during busy -> ignored; N=1, reward[0]=-3 -> done after 1 cycle, exp_out=-3, act_valid=0.
